// File: rtl/rgb_to_yuv_encoder_pkg.sv
// Shared definitions for the RGB-to-YUV encoder: FSM states, BT.601 coefficients
// (2^16 scale), rounding constant and the small saturate/average helpers.
package rgb_to_yuv_encoder_pkg;

    typedef enum logic [2:0] {
        S_ENC_IDLE,
        S_ENC_RD,
        S_ENC_CONV,
        S_ENC_WR,
        S_ENC_DONE
    } state_encoder_t;

    localparam logic signed [31:0] C_YR = 32'sd16843;
    localparam logic signed [31:0] C_YG = 32'sd33030;
    localparam logic signed [31:0] C_YB = 32'sd6423;
    localparam logic signed [31:0] C_UR = -32'sd9699;
    localparam logic signed [31:0] C_UG = -32'sd19071;
    localparam logic signed [31:0] C_UB = 32'sd28770;
    localparam logic signed [31:0] C_VR = 32'sd28770;
    localparam logic signed [31:0] C_VG = -32'sd24117;
    localparam logic signed [31:0] C_VB = -32'sd4653;

    localparam logic signed [31:0] ROUND_CONST = 32'sd32768;

    function automatic logic [7:0] clip_u8(input logic signed [31:0] x);
        if (x < 0)
            return '0;
        else if (x > 32'sd255)
            return '1;
        else
            return x[7:0];
    endfunction

    function automatic logic [7:0] avg_u8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

endpackage

// File: rtl/rgb_to_yuv_encoder_pixel.sv
// Per-pixel BT.601 converter: stage 1 registers the nine products, stage 2
// registers the rounded, offset and saturated Y/U/V. Latency is exactly 2.
module rgb_to_yuv_pixel
    import rgb_to_yuv_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_valid,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic       res_valid,
    output logic [7:0] y,
    output logic [7:0] u,
    output logic [7:0] v
);

    logic signed [31:0] prod [9];
    logic               stage1_valid;
    logic signed [31:0] r_s, g_s, b_s;
    logic signed [31:0] sum_y, sum_u, sum_v;

    assign r_s = $signed({24'd0, r});
    assign g_s = $signed({24'd0, g});
    assign b_s = $signed({24'd0, b});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_valid <= 1'b0;
            for (int unsigned i = 0; i < 9; i++)
                prod[i] <= '0;
        end else begin
            stage1_valid <= pix_valid;
            prod[0] <= r_s * C_YR;
            prod[1] <= g_s * C_YG;
            prod[2] <= b_s * C_YB;
            prod[3] <= r_s * C_UR;
            prod[4] <= g_s * C_UG;
            prod[5] <= b_s * C_UB;
            prod[6] <= r_s * C_VR;
            prod[7] <= g_s * C_VG;
            prod[8] <= b_s * C_VB;
        end
    end

    always_comb begin
        sum_y = prod[0] + prod[1] + prod[2] + ROUND_CONST;
        sum_u = prod[3] + prod[4] + prod[5] + ROUND_CONST;
        sum_v = prod[6] + prod[7] + prod[8] + ROUND_CONST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            y         <= '0;
            u         <= '0;
            v         <= '0;
        end else begin
            res_valid <= stage1_valid;
            y         <= clip_u8((sum_y >>> 16) + 32'sd16);
            u         <= clip_u8((sum_u >>> 16) + 32'sd128);
            v         <= clip_u8((sum_v >>> 16) + 32'sd128);
        end
    end

endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// Reads 4-pixel RGB groups from SRAM, converts them to BT.601 YUV and writes
// planar Y plus 2:1 horizontally decimated U/V back, 18 cycles per group.
module rgb_to_yuv_encoder
    import rgb_to_yuv_encoder_pkg::*;
#(
    parameter int unsigned NUM_GROUPS = 19200,
    parameter logic [17:0] Y_OFFSET   = 18'd0,
    parameter logic [17:0] U_OFFSET   = 18'd38400,
    parameter logic [17:0] V_OFFSET   = 18'd57600,
    parameter logic [17:0] RGB_OFFSET = 18'd146944
) (
    input  logic        Clock_50,
    input  logic        Resetn,
    input  logic        Start,
    output logic        Done,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data
);

    localparam logic [14:0] LAST_GROUP = 15'(NUM_GROUPS - 1);

    state_encoder_t state, state_nxt;
    logic [4:0]  step;
    logic [14:0] grp;
    logic [15:0] word [6];
    logic [7:0]  ypix [4];
    logic [7:0]  upix [4];
    logic [7:0]  vpix [4];
    logic [4:0]  word_idx, res_idx;
    logic [17:0] src_base, y_base;
    logic        pix_valid, res_valid;
    logic [7:0]  pix_r, pix_g, pix_b, res_y, res_u, res_v;
    logic [17:0] addr_nxt;
    logic [15:0] data_nxt;
    logic        we_n_nxt, done_nxt;

    assign src_base = RGB_OFFSET + 18'({grp, 2'b00}) + 18'({grp, 1'b0});
    assign y_base   = Y_OFFSET + 18'({grp, 1'b0});
    assign word_idx = step - 5'd3;
    assign res_idx  = step - 5'd10;

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn)
            state <= S_ENC_IDLE;
        else
            state <= state_nxt;
    end

    // step runs 0..17 across RD (0-7), CONV (8-13) and WR (14-17) of one group
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_ENC_IDLE: if (Start) state_nxt = S_ENC_RD;
            S_ENC_RD:   if (step == 5'd7) state_nxt = S_ENC_CONV;
            S_ENC_CONV: if (step == 5'd13) state_nxt = S_ENC_WR;
            S_ENC_WR:   if (step == 5'd17) state_nxt = (grp == LAST_GROUP) ? S_ENC_DONE : S_ENC_RD;
            S_ENC_DONE: state_nxt = S_ENC_IDLE;
            default:    state_nxt = S_ENC_IDLE;
        endcase
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            step <= '0;
            grp  <= '0;
        end else begin
            if (state == S_ENC_IDLE || state == S_ENC_DONE)
                step <= '0;
            else
                step <= (step == 5'd17) ? 5'd0 : step + 5'd1;
            if (state == S_ENC_DONE)
                grp <= '0;
            else if (state == S_ENC_WR && step == 5'd17 && grp != LAST_GROUP)
                grp <= grp + 15'd1;
        end
    end

    // Registered address lags the step by one cycle and the SRAM adds two more,
    // so word k is captured at the end of step k+3 (the last one in CONV step 8).
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int unsigned i = 0; i < 6; i++)
                word[i] <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                ypix[i] <= '0;
                upix[i] <= '0;
                vpix[i] <= '0;
            end
        end else begin
            if ((state == S_ENC_RD && step >= 5'd3) || (state == S_ENC_CONV && step == 5'd8))
                word[word_idx[2:0]] <= SRAM_read_data;
            if (state == S_ENC_CONV && res_valid) begin
                ypix[res_idx[1:0]] <= res_y;
                upix[res_idx[1:0]] <= res_u;
                vpix[res_idx[1:0]] <= res_v;
            end
        end
    end

    // CONV steps 8..11 feed pixels 0..3; step[1:0] is the pixel index there
    always_comb begin
        pix_valid = (state == S_ENC_CONV) && (step <= 5'd11);
        unique case (step[1:0])
            2'd0:    {pix_r, pix_g, pix_b} = {word[0], word[1][15:8]};
            2'd1:    {pix_r, pix_g, pix_b} = {word[1][7:0], word[2]};
            2'd2:    {pix_r, pix_g, pix_b} = {word[3], word[4][15:8]};
            default: {pix_r, pix_g, pix_b} = {word[4][7:0], word[5]};
        endcase
    end

    rgb_to_yuv_pixel u_pixel (
        .clk       (Clock_50),
        .rst_n     (Resetn),
        .pix_valid (pix_valid),
        .r         (pix_r),
        .g         (pix_g),
        .b         (pix_b),
        .res_valid (res_valid),
        .y         (res_y),
        .u         (res_u),
        .v         (res_v)
    );

    always_comb begin
        addr_nxt = SRAM_address;
        data_nxt = SRAM_write_data;
        we_n_nxt = 1'b1;
        done_nxt = 1'b0;
        unique case (state)
            S_ENC_RD: if (step <= 5'd5) addr_nxt = src_base + 18'(step);
            S_ENC_WR: begin
                we_n_nxt = 1'b0;
                unique case (step)
                    5'd14: begin
                        addr_nxt = y_base;
                        data_nxt = {ypix[0], ypix[1]};
                    end
                    5'd15: begin
                        addr_nxt = y_base + 18'd1;
                        data_nxt = {ypix[2], ypix[3]};
                    end
                    5'd16: begin
                        addr_nxt = U_OFFSET + 18'(grp);
                        data_nxt = {avg_u8(upix[0], upix[1]), avg_u8(upix[2], upix[3])};
                    end
                    default: begin
                        addr_nxt = V_OFFSET + 18'(grp);
                        data_nxt = {avg_u8(vpix[0], vpix[1]), avg_u8(vpix[2], vpix[3])};
                    end
                endcase
            end
            S_ENC_DONE: done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            Done            <= 1'b0;
        end else begin
            SRAM_address    <= addr_nxt;
            SRAM_write_data <= data_nxt;
            SRAM_we_n       <= we_n_nxt;
            Done            <= done_nxt;
        end
    end

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Self-checking bench for rgb_to_yuv_encoder with a 3-group image, an SRAM model
// with 2-cycle read latency and a write scoreboard.
module tb_rgb_to_yuv_encoder;

    localparam int NG    = 3;
    localparam int RGB_A = 146944;
    localparam int U_A   = 38400;
    localparam int V_A   = 57600;

    logic        Clock_50 = 1'b0;
    logic        Resetn   = 1'b0;
    logic        Start    = 1'b0;
    logic        Done;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;

    always #10 Clock_50 = ~Clock_50;

    rgb_to_yuv_encoder #(.NUM_GROUPS(NG)) dut (
        .Clock_50        (Clock_50),
        .Resetn          (Resetn),
        .Start           (Start),
        .Done            (Done),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data)
    );

    logic [15:0] mem [0:262143];
    logic [15:0] rd_p0 = '0, rd_p1 = '0;
    always @(posedge Clock_50) begin
        rd_p0 <= mem[SRAM_address];
        rd_p1 <= rd_p0;
    end
    assign SRAM_read_data = rd_p1;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, t_start = 0, done_cnt = 0, we_low_cnt = 0;
    bit active = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] clip8(input int x);
        if (x < 0) return 8'd0;
        if (x > 255) return 8'd255;
        return x[7:0];
    endfunction

    function automatic logic [23:0] ref_yuv(input int r, input int g, input int b);
        logic [7:0] y, u, v;
        y = clip8(((16843 * r + 33030 * g + 6423 * b + 32768) >>> 16) + 16);
        u = clip8(((-9699 * r - 19071 * g + 28770 * b + 32768) >>> 16) + 128);
        v = clip8(((28770 * r - 24117 * g - 4653 * b + 32768) >>> 16) + 128);
        return {y, u, v};
    endfunction

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = (int'(a) + int'(b) + 1) >> 1;
        return s[7:0];
    endfunction

    task automatic push(input int addr, input logic [15:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic push_model();
        logic [15:0] w [6];
        logic [7:0]  rgb [12];
        logic [23:0] p [4];
        for (int g = 0; g < NG; g++) begin
            for (int k = 0; k < 6; k++) begin
                w[k] = mem[RGB_A + 6 * g + k];
                rgb[2 * k]     = w[k][15:8];
                rgb[2 * k + 1] = w[k][7:0];
            end
            for (int i = 0; i < 4; i++)
                p[i] = ref_yuv(rgb[3 * i], rgb[3 * i + 1], rgb[3 * i + 2]);
            push(2 * g,     {p[0][23:16], p[1][23:16]});
            push(2 * g + 1, {p[2][23:16], p[3][23:16]});
            push(U_A + g,   {avg8(p[0][15:8], p[1][15:8]), avg8(p[2][15:8], p[3][15:8])});
            push(V_A + g,   {avg8(p[0][7:0], p[1][7:0]), avg8(p[2][7:0], p[3][7:0])});
        end
    endtask

    always @(posedge Clock_50) cyc <= cyc + 1;

    always @(negedge Clock_50) begin
        int rel, pos, g;
        if (Done) done_cnt++;
        if (Resetn && !SRAM_we_n) begin
            we_low_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_write: addr %0d data 0x%h, no write expected", SRAM_address, SRAM_write_data);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check_eq("wr_addr", 32'(SRAM_address), w.addr);
                check_eq("wr_data", 32'(SRAM_write_data), 32'(w.data));
            end
        end
        if (active) begin
            rel = cyc - t_start;
            if (rel >= 1 && rel <= 18 * NG + 1) begin
                check_eq("done_timing", 32'(Done), 32'(rel == 18 * NG + 1));
                if (rel <= 18 * NG) begin
                    pos = (rel - 1) % 18;
                    g   = (rel - 1) / 18;
                    if (pos < 6)
                        check_eq("rd_addr", 32'(SRAM_address), RGB_A + 6 * g + pos);
                    check_eq("we_n_timing", 32'(SRAM_we_n), 32'(pos < 14));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_done"}, 32'(Done), 0);
        check_eq({tag, "_we_n"}, 32'(SRAM_we_n), 1);
        check_eq({tag, "_addr"}, 32'(SRAM_address), 0);
        check_eq({tag, "_wdata"}, 32'(SRAM_write_data), 0);
    endtask

    // abort_rel != 0 pulls Resetn low in that cycle after the run started
    task automatic run_seq(input bit strays, input int abort_rel);
        int d0, w0, rel;
        bit aborted;
        aborted = 1'b0;
        d0 = done_cnt;
        w0 = we_low_cnt;
        @(negedge Clock_50);
        Start   = 1'b1;
        t_start = cyc + 1;
        active  = 1'b1;
        @(negedge Clock_50);
        Start = 1'b0;
        for (int i = 0; i < 18 * NG + 20; i++) begin
            @(negedge Clock_50);
            rel = cyc - t_start;
            Start = strays && (rel == 9 || rel == 18 * NG);
            if (abort_rel != 0 && rel == abort_rel) begin
                #5 Resetn = 1'b0;
                active = 1'b0;
                #1 check_reset_outputs("abort");
                exp_q.delete();
                aborted = 1'b1;
                break;
            end
            if (done_cnt != d0 && rel > 18 * NG + 1) break;
        end
        Start  = 1'b0;
        active = 1'b0;
        if (aborted) begin
            repeat (3) @(negedge Clock_50);
            Resetn = 1'b1;
            repeat (40) @(negedge Clock_50);
            check_eq("no_done_after_abort", done_cnt - d0, 0);
        end else begin
            repeat (25) @(negedge Clock_50);
            check_eq("done_count", done_cnt - d0, 1);
            check_eq("pending_writes", exp_q.size(), 0);
            check_eq("we_low_cycles", we_low_cnt - w0, 4 * NG);
        end
    endtask

    initial begin
        for (int i = 0; i < 18; i++) mem[RGB_A + i] = '0;
        repeat (2) @(negedge Clock_50);
        Start = 1'b1;
        @(negedge Clock_50);
        Start = 1'b0;
        repeat (2) @(negedge Clock_50);
        check_reset_outputs("reset");
        Resetn = 1'b1;
        repeat (3) @(negedge Clock_50);
        check_eq("idle_after_start_in_reset", 32'(SRAM_we_n), 1);
        check_eq("idle_done", done_cnt, 0);

        // group 0 black, group 1 white, group 2 red/black/red/red
        for (int i = 0; i < 6; i++) mem[RGB_A + i] = 16'h0000;
        for (int i = 6; i < 12; i++) mem[RGB_A + i] = 16'hFFFF;
        mem[RGB_A + 12] = 16'hFF00; mem[RGB_A + 13] = 16'h0000; mem[RGB_A + 14] = 16'h0000;
        mem[RGB_A + 15] = 16'hFF00; mem[RGB_A + 16] = 16'h00FF; mem[RGB_A + 17] = 16'h0000;
        push(0, 16'h1010); push(1, 16'h1010); push(U_A,     16'h8080); push(V_A,     16'h8080);
        push(2, 16'hEBEB); push(3, 16'hEBEB); push(U_A + 1, 16'h8080); push(V_A + 1, 16'h8080);
        push(4, 16'h5210); push(5, 16'h5252); push(U_A + 2, 16'h6D5A); push(V_A + 2, 16'hB8F0);
        run_seq(1'b1, 0);

        for (int i = 0; i < 18; i++) mem[RGB_A + i] = 16'($urandom);
        push_model();
        run_seq(1'b0, 18 + 16);

        push_model();
        run_seq(1'b0, 0);

        for (int i = 0; i < 18; i++) mem[RGB_A + i] = 16'($urandom);
        push_model();
        run_seq(1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
